pc_seq_unit: RTL and testbench

//   Parametrised program-counter sequencer for the fetch datapath. Holds the PC and

---
 rtl/pc_seq_unit.sv | 153 +++++++++++++++
 tb/tb_pc_seq_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// ---------------------------------------------------------------------------
// pc_seq_unit
//   Program-counter sequencer for the fetch datapath. Holds the PC and decodes
//   the next PC for sequential, conditional relative branch, absolute jump,
//   call and return operations. A small return-address stack backs CALL/RET.
//
// Ports
//   CLOCK      in   rising-edge clock
//   CLEAR      in   synchronous active-high reset (priority over stall/op)
//   stall      in   1 = hold PC, stack pointer, stack and error flags
//   op         in   3'b000 SEQ, 001 BR, 010 JMP, 011 CALL, 100 RET, others SEQ
//   cond       in   branch condition, used by BR only
//   offset     in   signed branch displacement (OW bits)
//   target     in   absolute target for JMP/CALL
//   pc         out  current PC (registered)
//   pc_next    out  combinational next PC from decode (ignores stall)
//   ret_top    out  top-of-stack entry, 0 when the stack is empty
//   stk_empty  out  stack holds no entries
//   stk_full   out  stack holds DEPTH entries
//   err_ovf    out  sticky: CALL attempted while full
//   err_unf    out  sticky: RET attempted while empty
// ---------------------------------------------------------------------------
module pc_seq_unit #(
  parameter int              AW       = 8,
  parameter int              OW       = 6,
  parameter int              STEP     = 2,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          CLOCK,
  input  logic          CLEAR,
  input  logic          stall,
  input  logic [2:0]    op,
  input  logic          cond,
  input  logic [OW-1:0] offset,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_next,
  output logic [AW-1:0] ret_top,
  output logic          stk_empty,
  output logic          stk_full,
  output logic          err_ovf,
  output logic          err_unf
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_ovf_q, err_ovf_d;
  logic           err_unf_q, err_unf_d;

  logic [AW-1:0]  seq;
  logic [AW-1:0]  off_ext;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;

  // Packed view of all stack entries, assembled from the per-entry registers.
  logic [DEPTH-1:0][AW-1:0] stk_all;

  assign full  = (sp_q == SP_FULL);
  assign empty = (sp_q == '0);

  // Sign-extend the displacement; sums below wrap modulo 2^AW.
  assign off_ext = AW'($signed(offset));
  assign seq     = pc_q + AW'(STEP);

  // Top-of-stack read: entry sp-1, or zero when empty.
  always_comb begin
    ret_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) begin
        ret_top = stk_all[i];
      end
    end
  end

  // Next-PC decode. Independent of stall so the fetch stage can look ahead.
  always_comb begin
    pc_next = seq;
    case (op)
      OP_BR:   pc_next = cond ? (seq + off_ext) : seq;
      OP_JMP:  pc_next = target;
      OP_CALL: pc_next = full  ? seq : target;
      OP_RET:  pc_next = empty ? seq : ret_top;
      default: pc_next = seq;
    endcase
  end

  // Stack and state updates happen only on an unstalled edge.
  always_comb begin
    push      = !stall && (op == OP_CALL) && !full;
    pop       = !stall && (op == OP_RET)  && !empty;
    pc_d      = stall ? pc_q : pc_next;
    sp_d      = sp_q;
    if (push) begin
      sp_d = sp_q + 1'b1;
    end else if (pop) begin
      sp_d = sp_q - 1'b1;
    end
    err_ovf_d = err_ovf_q | (!stall && (op == OP_CALL) && full);
    err_unf_d = err_unf_q | (!stall && (op == OP_RET)  && empty);
  end

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      pc_q      <= RESET_PC;
      sp_q      <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // One register per stack entry. Contents need no reset: sp gates every read.
  // CLEAR blocks the push so a CALL issued with CLEAR leaves no trace.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stk
    logic [AW-1:0] ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (push && !CLEAR && (sp_q == SPW'(gi))) begin
        ent_d = seq;
      end
    end

    always_ff @(posedge CLOCK) begin
      ent_q <= ent_d;
    end

    assign stk_all[gi] = ent_q;
  end

  assign pc        = pc_q;
  assign stk_empty = empty;
  assign stk_full  = full;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_seq_unit
//   Directed scoreboard bench for pc_seq_unit (default parameters). The
//   stimulus process drives one operation per cycle and queues the expected
//   combinational pc_next (due this cycle) and the expected registered state
//   (due the next cycle). The monitor samples on the falling edge and pops
//   every entry that is due.
// ---------------------------------------------------------------------------
module tb_pc_seq_unit;

  logic       clk;
  logic       clear;
  logic       stall;
  logic [2:0] op;
  logic       cond;
  logic [5:0] offset;
  logic [7:0] target;
  logic [7:0] pc;
  logic [7:0] pc_next;
  logic [7:0] ret_top;
  logic       stk_empty;
  logic       stk_full;
  logic       err_ovf;
  logic       err_unf;

  pc_seq_unit dut (
    .CLOCK     (clk),
    .CLEAR     (clear),
    .stall     (stall),
    .op        (op),
    .cond      (cond),
    .offset    (offset),
    .target    (target),
    .pc        (pc),
    .pc_next   (pc_next),
    .ret_top   (ret_top),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  localparam logic [2:0] SEQ  = 3'b000;
  localparam logic [2:0] BR   = 3'b001;
  localparam logic [2:0] JMP  = 3'b010;
  localparam logic [2:0] CALL = 3'b011;
  localparam logic [2:0] RET  = 3'b100;

  typedef struct {
    int          due;
    bit          is_state;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_rt;
    logic [3:0]  exp_flags;   // {empty, full, ovf, unf}
    string       name;
  } chk_t;

  chk_t q[$];
  int   cycle   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Monitor: compare every queued expectation that is due this cycle.
  initial begin
    chk_t c;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cycle) begin
        c = q.pop_front();
        n_tests++;
        if (c.is_state) begin
          if (pc !== c.exp_pc || ret_top !== c.exp_rt ||
              {stk_empty, stk_full, err_ovf, err_unf} !== c.exp_flags) begin
            n_fail++;
            $display("FAIL %s: pc=%h rt=%h flags(e,f,o,u)=%b, expected pc=%h rt=%h flags=%b",
                     c.name, pc, ret_top, {stk_empty, stk_full, err_ovf, err_unf},
                     c.exp_pc, c.exp_rt, c.exp_flags);
          end else begin
            $display("[TB] %s: pc=%h rt=%h flags=%b ok", c.name, pc, ret_top,
                     {stk_empty, stk_full, err_ovf, err_unf});
          end
        end else begin
          if (pc_next !== c.exp_pc) begin
            n_fail++;
            $display("FAIL %s.pc_next: got %h, expected %h", c.name, pc_next, c.exp_pc);
          end else begin
            $display("[TB] %s.pc_next: %h ok", c.name, pc_next);
          end
        end
      end
    end
  end

  // One cycle of stimulus plus its expectations.
  task automatic step(input string name, input logic clr, input logic stl,
                      input logic [2:0] o, input logic cnd, input logic [5:0] off,
                      input logic [7:0] tgt, input bit chk_next,
                      input logic [7:0] exp_next, input logic [7:0] exp_pc,
                      input logic [7:0] exp_rt, input logic [3:0] exp_flags);
    chk_t c;
    @(posedge clk);
    #1;
    clear  = clr;
    stall  = stl;
    op     = o;
    cond   = cnd;
    offset = off;
    target = tgt;
    if (chk_next) begin
      c.due = cycle; c.is_state = 1'b0; c.exp_pc = exp_next;
      c.exp_rt = '0; c.exp_flags = '0; c.name = name;
      q.push_back(c);
    end
    c.due = cycle + 1; c.is_state = 1'b1; c.exp_pc = exp_pc;
    c.exp_rt = exp_rt; c.exp_flags = exp_flags; c.name = name;
    q.push_back(c);
  endtask

  initial begin
    clear = 1'b1; stall = 1'b0; op = SEQ; cond = 1'b0; offset = '0; target = '0;

    // 1: reset and sequential stepping
    step("rst0",   1, 0, SEQ, 0, 6'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 4'b1000);
    step("rst1",   1, 0, SEQ, 0, 6'h00, 8'h00, 1, 8'h02, 8'h00, 8'h00, 4'b1000);
    step("seq1",   0, 0, SEQ, 0, 6'h00, 8'h00, 1, 8'h02, 8'h02, 8'h00, 4'b1000);
    step("seq2",   0, 0, SEQ, 0, 6'h00, 8'h00, 1, 8'h04, 8'h04, 8'h00, 4'b1000);
    step("seq3",   0, 0, 3'b111, 0, 6'h00, 8'h00, 1, 8'h06, 8'h06, 8'h00, 4'b1000);
    step("seq4",   0, 0, SEQ, 0, 6'h00, 8'h00, 1, 8'h08, 8'h08, 8'h00, 4'b1000);

    // 2: branches and wrap
    step("jmp10a", 0, 0, JMP, 0, 6'h00, 8'h10, 1, 8'h10, 8'h10, 8'h00, 4'b1000);
    step("br_t",   0, 0, BR,  1, 6'h3C, 8'h00, 1, 8'h0E, 8'h0E, 8'h00, 4'b1000);
    step("jmp10b", 0, 0, JMP, 0, 6'h00, 8'h10, 1, 8'h10, 8'h10, 8'h00, 4'b1000);
    step("br_nt",  0, 0, BR,  0, 6'h3C, 8'h00, 1, 8'h12, 8'h12, 8'h00, 4'b1000);
    step("br_fwd", 0, 0, BR,  1, 6'h05, 8'h00, 1, 8'h19, 8'h19, 8'h00, 4'b1000);
    step("jmpFE",  0, 0, JMP, 0, 6'h00, 8'hFE, 1, 8'hFE, 8'hFE, 8'h00, 4'b1000);
    step("wrap",   0, 0, SEQ, 0, 6'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00, 4'b1000);

    // 3: nested call / return
    step("jmp20",  0, 0, JMP,  0, 6'h00, 8'h20, 1, 8'h20, 8'h20, 8'h00, 4'b1000);
    step("call40", 0, 0, CALL, 0, 6'h00, 8'h40, 1, 8'h40, 8'h40, 8'h22, 4'b0000);
    step("call60", 0, 0, CALL, 0, 6'h00, 8'h60, 1, 8'h60, 8'h60, 8'h42, 4'b0000);
    step("ret1",   0, 0, RET,  0, 6'h00, 8'h00, 1, 8'h42, 8'h42, 8'h22, 4'b0000);
    step("ret2",   0, 0, RET,  0, 6'h00, 8'h00, 1, 8'h22, 8'h22, 8'h00, 4'b1000);

    // 4: overflow and underflow
    step("c1",     0, 0, CALL, 0, 6'h00, 8'h30, 1, 8'h30, 8'h30, 8'h24, 4'b0000);
    step("c2",     0, 0, CALL, 0, 6'h00, 8'h40, 1, 8'h40, 8'h40, 8'h32, 4'b0000);
    step("c3",     0, 0, CALL, 0, 6'h00, 8'h50, 1, 8'h50, 8'h50, 8'h42, 4'b0000);
    step("c4",     0, 0, CALL, 0, 6'h00, 8'h60, 1, 8'h60, 8'h60, 8'h52, 4'b0100);
    step("c5ovf",  0, 0, CALL, 0, 6'h00, 8'h70, 1, 8'h62, 8'h62, 8'h52, 4'b0110);
    step("r1",     0, 0, RET,  0, 6'h00, 8'h00, 1, 8'h52, 8'h52, 8'h42, 4'b0010);
    step("r2",     0, 0, RET,  0, 6'h00, 8'h00, 1, 8'h42, 8'h42, 8'h32, 4'b0010);
    step("r3",     0, 0, RET,  0, 6'h00, 8'h00, 1, 8'h32, 8'h32, 8'h24, 4'b0010);
    step("r4",     0, 0, RET,  0, 6'h00, 8'h00, 1, 8'h24, 8'h24, 8'h00, 4'b1010);
    step("r5unf",  0, 0, RET,  0, 6'h00, 8'h00, 1, 8'h26, 8'h26, 8'h00, 4'b1011);

    // 5: stall holds state while pc_next tracks inputs
    step("stl1",   0, 1, JMP, 0, 6'h00, 8'hAA, 1, 8'hAA, 8'h26, 8'h00, 4'b1011);
    step("stl2",   0, 1, JMP, 0, 6'h00, 8'hAA, 1, 8'hAA, 8'h26, 8'h00, 4'b1011);
    step("stl3",   0, 1, CALL, 0, 6'h00, 8'hAA, 1, 8'hAA, 8'h26, 8'h00, 4'b1011);
    step("unstl",  0, 0, JMP, 0, 6'h00, 8'hAA, 1, 8'hAA, 8'hAA, 8'h00, 4'b1011);

    // 6: CLEAR beats stall and CALL
    step("callB0", 0, 0, CALL, 0, 6'h00, 8'hB0, 1, 8'hB0, 8'hB0, 8'hAC, 4'b0011);
    step("clrcl",  1, 1, CALL, 0, 6'h00, 8'hC0, 1, 8'hC0, 8'h00, 8'h00, 4'b1000);
    step("post",   0, 0, SEQ,  0, 6'h00, 8'h00, 1, 8'h02, 8'h02, 8'h00, 4'b1000);

    @(posedge clk);
    #1;
    op = SEQ; stall = 1'b1; clear = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
